// File: rtl/clk_divider_prog.sv
// Programmable clock divider: phase counter, glitch-free divided clock (50% or pulse),
// and a pending ratio/mode register that is applied only at the period boundary.
module clk_divider_prog #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  input  logic             i_mode,
  input  logic             i_div_load,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_div_clk,
  output logic             o_load_pending,
  output logic [WIDTH-1:0] o_ratio_active
);

  localparam logic [WIDTH-1:0] DEF_RATIO =
    (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] r);
    return (r < WIDTH'(2)) ? WIDTH'(2) : r;
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_mode_q, pend_mode_d;
  logic             rise_q, rise_d;
  logic             fall_q;
  logic             wrap;
  logic [WIDTH-1:0] half;

  // ratio_q >= 2, so ratio_q-1 never underflows and count_q+1 never exceeds ratio_q
  assign wrap = (count_q == ratio_q - WIDTH'(1)) && i_clk_en;
  assign half = ratio_q >> 1;

  always_comb begin
    count_d      = count_q;
    ratio_d      = ratio_q;
    mode_d       = mode_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    pend_mode_d  = pend_mode_q;
    rise_d       = rise_q;

    if (i_div_load) begin
      pend_ratio_d = clamp_ratio(i_div_ratio);
      pend_mode_d  = i_mode;
      pend_d       = 1'b1;
    end

    if (wrap) begin
      count_d = '0;
      rise_d  = 1'b1;
      pend_d  = 1'b0;
      if (i_div_load) begin
        ratio_d = clamp_ratio(i_div_ratio);
        mode_d  = i_mode;
      end else if (pend_q) begin
        ratio_d = pend_ratio_q;
        mode_d  = pend_mode_q;
      end
    end else if (i_clk_en) begin
      count_d = count_q + WIDTH'(1);
      // odd and even N share the same rising-edge drop point; odd N is stretched by fall_q
      if (mode_q || (count_d == half)) rise_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      ratio_q      <= DEF_RATIO;
      mode_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_ratio_q <= DEF_RATIO;
      pend_mode_q  <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      ratio_q      <= ratio_d;
      mode_q       <= mode_d;
      pend_q       <= pend_d;
      pend_ratio_q <= pend_ratio_d;
      pend_mode_q  <= pend_mode_d;
      rise_q       <= rise_d;
    end
  end

  // Half-cycle delayed copy, only live in 50% mode with odd N
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      fall_q <= 1'b0;
    end else if (i_clk_en) begin
      fall_q <= rise_q & ~mode_q & ratio_q[0];
    end
  end

  assign o_count        = count_q;
  assign o_count_end    = wrap;
  assign o_div_clk      = rise_q | fall_q;
  assign o_load_pending = pend_q;
  assign o_ratio_active = ratio_q;

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter and ratio width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 7, meaning the divide ratio applied out of reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. Rising edge is the primary edge; the falling edge is used only per REQ-016.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_clk_en, input, 1 bit: count enable; when low, all state holds.
REQ-006 SHALL have port i_div_ratio, input, WIDTH bits: requested divide ratio N.
REQ-007 SHALL have port i_mode, input, 1 bit: requested output mode; 0 = 50% duty, 1 = single-cycle pulse.
REQ-008 SHALL have port i_div_load, input, 1 bit: one-cycle strobe that captures i_div_ratio and i_mode into a pending register.
REQ-009 SHALL have port o_count, output, WIDTH bits: current phase counter value.
REQ-010 SHALL have port o_count_end, output, 1 bit: terminal-count flag.
REQ-011 SHALL have port o_div_clk, output, 1 bit: divided clock output.
REQ-012 SHALL have port o_load_pending, output, 1 bit: high while a captured ratio/mode is waiting to be applied.
REQ-013 SHALL have port o_ratio_active, output, WIDTH bits: the ratio N currently in effect.

Function
REQ-014 SHALL advance o_count on each rising edge of clk with i_clk_en=1, counting 0,1,..,N-1,0; it SHALL hold when i_clk_en=0.
REQ-015 SHALL drive o_count_end combinationally as (o_count==N-1) AND i_clk_en.
REQ-016 In mode 0 with even N, o_div_clk SHALL rise at the rising edge where o_count becomes 0 and fall at the rising edge where o_count becomes N/2. With odd N, it SHALL rise at the rising edge where o_count becomes 0 and fall at the falling edge of clk in the cycle where o_count==(N-1)/2, giving a high time of N/2 clk periods. The falling-edge register SHALL be reset by reset.
REQ-017 In mode 1, o_div_clk SHALL be high exactly during the clk cycles in which o_count==0, and only while i_clk_en=1 in that cycle.
REQ-018 SHALL clamp a captured i_div_ratio of 0 or 1 to 2; ratio arithmetic SHALL be unsigned at WIDTH bits, and half-period comparisons SHALL not overflow at N=2^WIDTH-1.
REQ-019 A rising edge with i_div_load=1 SHALL capture the ratio and mode into the pending register and set o_load_pending=1, regardless of i_clk_en.
REQ-020 Pending values SHALL be applied only at a wrap (o_count_end=1 at that rising edge). At that edge o_ratio_active and the mode update, o_count goes to 0, and o_load_pending clears. Ratio and mode therefore never change mid-period.
REQ-021 If i_div_load=1 and a wrap occur on the same edge, the newly presented values SHALL be applied at that wrap, and o_load_pending SHALL be 0 afterward.
REQ-022 A second i_div_load before the wrap SHALL overwrite the pending values (last write wins).
REQ-023 While i_clk_en=0, o_div_clk SHALL hold its current level; in mode 0 with odd N, a scheduled falling-edge transition SHALL also be suppressed.
REQ-024 o_count, o_ratio_active and o_load_pending SHALL be registered outputs; o_div_clk SHALL come only from registers (OR/AND of the rising- and falling-edge registers), never directly from combinational decode, so it is glitch-free.

Reset
REQ-025 Assertion of reset SHALL immediately and asynchronously set: o_count=0, o_div_clk=0, falling-edge register=0, o_load_pending=0, o_ratio_active=DEFAULT_DIV (clamped per REQ-018), mode=0.
REQ-026 Reset asserted mid-period SHALL discard any pending load. After deassertion, the first enabled rising edge SHALL move o_count to 1, and o_div_clk SHALL first rise at the first wrap.

Verification
REQ-027 Defaults, 2 ns clk, i_clk_en=1, reset deasserted at 20 ns -> o_count cycles 0..6, o_count_end pulses every 7 cycles, o_div_clk period 14 ns with high time 7 ns.
REQ-028 Load N=4, mode 0 mid-period (o_count=3) -> o_load_pending=1 until the next wrap; the old 7-cycle period completes, then period is 8 ns with high time 4 ns, and o_ratio_active=4.
REQ-029 Load N=5, mode 1 coincident with o_count_end -> applied at that edge with o_load_pending=0; o_div_clk is high 2 ns out of every 10 ns.
REQ-030 Load N=0, then N=1, then N=15 before a wrap -> N=15 is applied at the wrap (with 0 or 1 last, N=2 is applied: period 4 ns); for N=15, high time is 15 ns with no glitches.
REQ-031 i_clk_en=0 for 5 cycles at o_count=2 with N=7 -> o_count, o_div_clk and o_count_end hold at 2/high/0, and the period resumes extended by exactly 10 ns.
REQ-032 Reset pulsed for 3 ns at o_count=5 with a load pending -> all outputs at reset values during the pulse, pending discarded, o_ratio_active=7.
